// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - requester/transmitter signal bundle for uart_tx_arb
//
// Signal names carry their direction as seen from the arbiter (_i into it, _o out of it).
//   req0_data_i/req0_we_i/req0_full_o : requester 0 byte, push strobe, FIFO full
//   req1_data_i/req1_we_i/req1_full_o : requester 1 byte, push strobe, FIFO full
//   tx_data_o/tx_we_o/tx_ready_i      : byte, send strobe and idle flag of the UART transmitter
//   grant_o                           : requester that owns the current or last transfer
//   busy_o                            : work pending in a FIFO or a transfer in progress
// The arbiter connects through the slave modport; whatever drives it connects through master.
interface uart_tx_arb_if;
    logic [7:0] req0_data_i;
    logic       req0_we_i;
    logic       req0_full_o;
    logic [7:0] req1_data_i;
    logic       req1_we_i;
    logic       req1_full_o;
    logic [7:0] tx_data_o;
    logic       tx_we_o;
    logic       tx_ready_i;
    logic       grant_o;
    logic       busy_o;

    modport slave (
        input  req0_data_i, req0_we_i, req1_data_i, req1_we_i, tx_ready_i,
        output req0_full_o, req1_full_o, tx_data_o, tx_we_o, grant_o, busy_o
    );

    modport master (
        output req0_data_i, req0_we_i, req1_data_i, req1_we_i, tx_ready_i,
        input  req0_full_o, req1_full_o, tx_data_o, tx_we_o, grant_o, busy_o
    );
endinterface

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - two-requester byte arbiter feeding one UART transmitter
//
// Each requester pushes bytes into its own 2^FIFO_AW-deep FIFO. An FSM
// (IDLE -> ISSUE -> WAIT_LO -> WAIT_HI) pops one byte at a time, pulses
// tx_we_o for one cycle and then follows tx_ready_i low and back high before
// the next byte. With both FIFOs non-empty the requester that did not own the
// last transfer wins; the very first tie after reset goes to requester 0.
//
// Ports:
//   clk_i  : sole clock, all state on the rising edge
//   rst_i  : synchronous reset, active high
//   bus    : uart_tx_arb_if.slave (requester pushes/full flags, transmitter
//            data/strobe/ready, grant and busy)
//
// Optional feature: define UART_ARB_LINE_LOCK_EN to keep a granted requester
// exclusively eligible until it sends 0x0A, or until its FIFO has been empty
// for LOCK_TMO consecutive IDLE cycles.
module uart_tx_arb #(
    parameter int FIFO_AW  = 2,
    parameter int LOCK_TMO = 1023
) (
    input logic          clk_i,
    input logic          rst_i,
    uart_tx_arb_if.slave bus
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} state_t;

    state_t             state_q;
    logic [7:0]         tx_data_q;
    logic               tx_we_q;
    logic               grant_q;
    logic               granted_q;   // set once any byte has been issued since reset

    logic [7:0]         mem_q    [2][DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q [2];
    logic [FIFO_AW-1:0] rd_ptr_q [2];
    logic [FIFO_AW:0]   cnt_q    [2];
    logic [FIFO_AW:0]   cnt_d    [2];
    logic               full_q   [2];
    logic               push     [2];
    logic               pop      [2];
    logic [7:0]         push_data[2];
    logic               push_we  [2];

    logic               elig0, elig1;
    logic               pick_valid;
    logic               pick_idx;
    logic               issue;
    logic [7:0]         head;

`ifdef UART_ARB_LINE_LOCK_EN
    localparam int LCW = (LOCK_TMO > 0) ? $clog2(LOCK_TMO + 1) : 1;
    logic           lock_q;      // owner is always grant_q
    logic [LCW-1:0] lock_cnt_q;  // consecutive IDLE cycles with the owner's FIFO empty
`endif

    assign push_data[0] = bus.req0_data_i;
    assign push_data[1] = bus.req1_data_i;
    assign push_we[0]   = bus.req0_we_i;
    assign push_we[1]   = bus.req1_we_i;

    // Arbitration and FIFO bookkeeping
    always_comb begin
        elig0 = (cnt_q[0] != '0);
        elig1 = (cnt_q[1] != '0);
`ifdef UART_ARB_LINE_LOCK_EN
        if (lock_q) begin
            elig0 = elig0 && !grant_q;
            elig1 = elig1 && grant_q;
        end
`endif
        pick_valid = elig0 || elig1;
        if (elig0 && elig1) begin
            pick_idx = granted_q ? !grant_q : 1'b0;
        end else begin
            pick_idx = elig1;
        end
        issue = (state_q == IDLE) && bus.tx_ready_i && pick_valid;
        head  = mem_q[pick_idx][rd_ptr_q[pick_idx]];

        pop[0] = issue && !pick_idx;
        pop[1] = issue && pick_idx;
        for (int i = 0; i < 2; i++) begin
            // full_q is the registered flag, so a push into a full FIFO is
            // refused even when the same edge pops it.
            push[i]  = push_we[i] && !full_q[i];
            cnt_d[i] = cnt_q[i] + {{FIFO_AW{1'b0}}, push[i]} - {{FIFO_AW{1'b0}}, pop[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= push_data[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                full_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                end
                cnt_q[i]  <= cnt_d[i];
                full_q[i] <= (cnt_d[i] == DEPTH_CNT);
            end
        end
    end

    // Transfer FSM with registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_we_q    <= 1'b0;
            grant_q    <= 1'b0;
            granted_q  <= 1'b0;
`ifdef UART_ARB_LINE_LOCK_EN
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        tx_data_q <= head;
                        tx_we_q   <= 1'b1;
                        grant_q   <= pick_idx;
                        granted_q <= 1'b1;
                        state_q   <= ISSUE;
`ifdef UART_ARB_LINE_LOCK_EN
                        // A newline ends the line; anything else (re)arms the lock.
                        lock_q     <= (head != 8'h0A);
                        lock_cnt_q <= '0;
`endif
                    end
`ifdef UART_ARB_LINE_LOCK_EN
                    else if (lock_q) begin
                        if (cnt_q[grant_q] != '0) begin
                            lock_cnt_q <= '0;
                        end else if (lock_cnt_q == LCW'(LOCK_TMO)) begin
                            lock_q     <= 1'b0;
                            lock_cnt_q <= '0;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                ISSUE: begin
                    tx_we_q <= 1'b0;
                    state_q <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!bus.tx_ready_i) begin
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (bus.tx_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_full_o = full_q[0];
    assign bus.req1_full_o = full_q[1];
    assign bus.tx_data_o   = tx_data_q;
    assign bus.tx_we_o     = tx_we_q;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = (cnt_q[0] != '0) || (cnt_q[1] != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arb_if bus();

    uart_tx_arb #(.FIFO_AW(2), .LOCK_TMO(1023)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_we  = 0;

    typedef struct packed {
        logic       g;
        logic [7:0] d;
    } exp_t;
    exp_t sbq[$];

    logic model_en;
    logic model_ready;
    logic manual_ready;
    assign bus.tx_ready_i = model_en ? model_ready : manual_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input logic g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic push2(input logic w0, input logic [7:0] d0, input logic w1, input logic [7:0] d1);
        @(posedge clk); #1;
        bus.req0_we_i   = w0;
        bus.req0_data_i = d0;
        bus.req1_we_i   = w1;
        bus.req1_data_i = d1;
        @(posedge clk); #1;
        bus.req0_we_i   = 1'b0;
        bus.req1_we_i   = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int c = 0;
        while (sbq.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(name, 32'(sbq.size()), 32'd0);
        repeat (12) @(posedge clk);
    endtask

    // Scoreboard: every send strobe must match the oldest expected byte.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.tx_we_o === 1'b1) begin
                n_we++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tx_we: tx_data 0x%0h with no byte expected", bus.tx_data_o);
                end else begin
                    e = sbq.pop_front();
                    check("tx_data", 32'(bus.tx_data_o), 32'(e.d));
                    check("grant", 32'(bus.grant_o), 32'(e.g));
                end
            end
        end
    end

    // Transmitter model: ready drops the cycle after the strobe, returns later.
    initial begin
        model_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (model_en === 1'b1 && bus.tx_we_o === 1'b1) begin
                @(posedge clk); #1 model_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 model_ready = 1'b1;
            end
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       exp_full;
        logic       accepted;
    } vec_t;

    initial begin
        vec_t tv[5];
        int   we_before;
        int   c;

        tv[0] = '{8'h01, 1'b0, 1'b1};
        tv[1] = '{8'h02, 1'b0, 1'b1};
        tv[2] = '{8'h03, 1'b0, 1'b1};
        tv[3] = '{8'h04, 1'b1, 1'b1};
        tv[4] = '{8'h05, 1'b1, 1'b0};

        rst = 1'b1;
        model_en = 1'b0;
        manual_ready = 1'b1;
        bus.req0_we_i = 1'b0;
        bus.req1_we_i = 1'b0;
        bus.req0_data_i = 8'h00;
        bus.req1_data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_tx_we", 32'(bus.tx_we_o), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
        check("rst_grant", 32'(bus.grant_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_full0", 32'(bus.req0_full_o), 32'd0);
        check("rst_full1", 32'(bus.req1_full_o), 32'd0);

        // Single byte latency on an idle line
        model_en = 1'b1;
        expect_byte(1'b0, 8'h41);
        push2(1'b1, 8'h41, 1'b0, 8'h00);
        @(negedge clk);
        check("lat_early_we", 32'(bus.tx_we_o), 32'd0);
        @(negedge clk);
        check("lat_strobe_we", 32'(bus.tx_we_o), 32'd1);
        check("lat_strobe_data", 32'(bus.tx_data_o), 32'h41);
        @(negedge clk);
        check("strobe_one_cycle", 32'(bus.tx_we_o), 32'd0);
        drain(200, "drain_single");
        check("data_held", 32'(bus.tx_data_o), 32'h41);
        check("idle_busy", 32'(bus.busy_o), 32'd0);

        // Fill requester 1 past full with the transmitter held busy
        model_en = 1'b0;
        manual_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push2(1'b0, 8'h00, 1'b1, tv[i].d);
            check("full1_after_push", 32'(bus.req1_full_o), 32'(tv[i].exp_full));
            if (tv[i].accepted) expect_byte(1'b1, tv[i].d);
        end
        check("busy_pending", 32'(bus.busy_o), 32'd1);
        model_en = 1'b1;
        drain(400, "drain_fill");
        check("full1_after_drain", 32'(bus.req1_full_o), 32'd0);
        check("data_held_fill", 32'(bus.tx_data_o), 32'h04);

`ifdef UART_ARB_LINE_LOCK_EN
        // Locked line ends on newline, then the other requester runs
        do_reset();
        model_en = 1'b0;
        manual_ready = 1'b0;
        push2(1'b1, 8'h61, 1'b1, 8'h78);
        push2(1'b1, 8'h62, 1'b1, 8'h79);
        push2(1'b1, 8'h0A, 1'b0, 8'h00);
        expect_byte(1'b0, 8'h61);
        expect_byte(1'b0, 8'h62);
        expect_byte(1'b0, 8'h0A);
        expect_byte(1'b1, 8'h78);
        expect_byte(1'b1, 8'h79);
        model_en = 1'b1;
        drain(500, "drain_lock_nl");

        // No newline: the other requester waits for the lock timeout
        do_reset();
        model_en = 1'b0;
        manual_ready = 1'b0;
        push2(1'b1, 8'h61, 1'b1, 8'h78);
        push2(1'b1, 8'h62, 1'b1, 8'h79);
        expect_byte(1'b0, 8'h61);
        expect_byte(1'b0, 8'h62);
        expect_byte(1'b1, 8'h78);
        expect_byte(1'b1, 8'h79);
        model_en = 1'b1;
        drain(5000, "drain_lock_tmo");
`else
        // Round-robin alternation starting from requester 0 after reset
        do_reset();
        model_en = 1'b0;
        manual_ready = 1'b0;
        push2(1'b1, 8'hA0, 1'b1, 8'hB0);
        push2(1'b1, 8'hA1, 1'b1, 8'hB1);
        expect_byte(1'b0, 8'hA0);
        expect_byte(1'b1, 8'hB0);
        expect_byte(1'b0, 8'hA1);
        expect_byte(1'b1, 8'hB1);
        model_en = 1'b1;
        drain(500, "drain_rr");
`endif

        // Reset during WAIT_HI with both FIFOs holding bytes
        do_reset();
        model_en = 1'b0;
        manual_ready = 1'b0;
        push2(1'b1, 8'hC0, 1'b1, 8'hD0);
        push2(1'b1, 8'hC1, 1'b1, 8'hD1);
        expect_byte(1'b0, 8'hC0);
        manual_ready = 1'b1;
        c = 0;
        while (bus.tx_we_o !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("mid_reset_strobe_seen", 32'(bus.tx_we_o), 32'd1);
        @(posedge clk); #1 manual_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        manual_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_tx_we", 32'(bus.tx_we_o), 32'd0);
        check("mid_rst_tx_data", 32'(bus.tx_data_o), 32'd0);
        check("mid_rst_grant", 32'(bus.grant_o), 32'd0);
        check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        check("mid_rst_full0", 32'(bus.req0_full_o), 32'd0);
        check("mid_rst_full1", 32'(bus.req1_full_o), 32'd0);
        we_before = n_we;
        repeat (30) @(negedge clk);
        check("no_we_after_rst", 32'(n_we), 32'(we_before));
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
